ritc_phase_shift_controller: RTL and testbench

RITC_PHASE_SHIFT_CONTROLLER -- requirements
Module: ritc_phase_shift_controller

---
 rtl/ritc_phase_shift_controller_pkg.sv | 25 ++
 rtl/ritc_phase_shift_controller.sv | 154 +++++++++++++++
 tb/tb_ritc_phase_shift_controller.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ritc_phase_shift_controller_pkg.sv
// Shared definitions for the RITC MMCM phase-shift interface: control/status bit
// positions, controller state encoding and the wrapping position helper.
package ritc_phase_shift_controller_pkg;

   localparam int unsigned PSEN_BIT     = 0;
   localparam int unsigned PSINCDEC_BIT = 1;
   localparam int unsigned PSRST_BIT    = 7;
   localparam int unsigned PSDONE_BIT   = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_STEP = 2'd1,
      ST_WAIT = 2'd2,
      ST_RST  = 2'd3
   } ps_state_t;

   // One fine-phase step with wrap inside 0..last.
   function automatic logic [15:0] wrap_step(input logic [15:0] pos,
                                             input logic        up,
                                             input logic [15:0] last);
      if (up) return (pos == last) ? 16'd0 : pos + 16'd1;
      else    return (pos == 16'd0) ? last : pos - 16'd1;
   endfunction

endpackage

// File: rtl/ritc_phase_shift_controller.sv
// Sequences MMCM fine-phase steps (PSEN/PSINCDEC with PSDONE handshake) and MMCM
// resets, tracking the resulting phase position modulo one CLKOUT1 period.
module ritc_phase_shift_controller
   import ritc_phase_shift_controller_pkg::*;
#(
   parameter int unsigned POS_MODULO     = 672,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned RST_HOLD       = 8
) (
   input  logic        phase_control_clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_steps,
   input  logic        cmd_reset,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] position,
   output logic [7:0]  phase_control_in,
   input  logic [7:0]  phase_control_out
);

   localparam logic [15:0] POS_LAST = 16'(POS_MODULO - 1);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0] RST_LAST = 16'(RST_HOLD - 1);

   ps_state_t   r_state;
   logic [15:0] r_remaining;
   logic [15:0] r_timeout;
   logic [15:0] r_rst_cnt;
   logic        r_dir;
   logic        r_psen;
   logic        r_psincdec;
   logic        r_psrst;
   logic [15:0] r_position;
   logic        r_done;
   logic        r_error;
   logic        r_ready;
   logic        r_busy;

   logic        w_psdone;
   logic        w_dir_up;
   logic [15:0] w_mag;
   logic [7:0]  w_pci;

   assign w_psdone = phase_control_out[PSDONE_BIT];
   assign w_dir_up = ~cmd_steps[15];
   // Two's-complement negate: 16'h8000 maps to 32768 as an unsigned magnitude.
   assign w_mag    = cmd_steps[15] ? (~cmd_steps + 16'd1) : cmd_steps;

   always_ff @(posedge phase_control_clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_remaining <= '0;
         r_timeout   <= '0;
         r_rst_cnt   <= '0;
         r_dir       <= 1'b0;
         r_psen      <= 1'b0;
         r_psincdec  <= 1'b0;
         r_psrst     <= 1'b0;
         r_position  <= '0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_ready     <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  if (cmd_reset) begin
                     r_state    <= ST_RST;
                     r_psrst    <= 1'b1;
                     r_rst_cnt  <= '0;
                     r_position <= '0;
                     r_ready    <= 1'b0;
                     r_busy     <= 1'b1;
                  end else if (cmd_steps == 16'd0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state     <= ST_STEP;
                     r_remaining <= w_mag;
                     r_dir       <= w_dir_up;
                     r_psen      <= 1'b1;
                     r_psincdec  <= w_dir_up;
                     r_ready     <= 1'b0;
                     r_busy      <= 1'b1;
                  end
               end
            end
            ST_STEP: begin
               r_state   <= ST_WAIT;
               r_psen    <= 1'b0;
               r_timeout <= '0;
            end
            ST_WAIT: begin
               if (w_psdone) begin
                  r_position  <= wrap_step(r_position, r_dir, POS_LAST);
                  r_remaining <= r_remaining - 16'd1;
                  r_timeout   <= '0;
                  if (r_remaining == 16'd1) begin
                     r_state <= ST_IDLE;
                     r_done  <= 1'b1;
                     r_ready <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= ST_STEP;
                     r_psen  <= 1'b1;
                  end
               end else if (r_timeout == TO_LAST) begin
                  // PSDONE never came: drop the rest, position keeps its last good value.
                  r_state     <= ST_IDLE;
                  r_error     <= 1'b1;
                  r_remaining <= '0;
                  r_timeout   <= '0;
                  r_ready     <= 1'b1;
                  r_busy      <= 1'b0;
               end else begin
                  r_timeout <= r_timeout + 16'd1;
               end
            end
            ST_RST: begin
               if (r_rst_cnt == RST_LAST) begin
                  r_state <= ST_IDLE;
                  r_psrst <= 1'b0;
                  r_done  <= 1'b1;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_rst_cnt <= r_rst_cnt + 16'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_pci               = '0;
      w_pci[PSEN_BIT]     = r_psen;
      w_pci[PSINCDEC_BIT] = r_psincdec;
      w_pci[PSRST_BIT]    = r_psrst;
   end

   assign phase_control_in = w_pci;
   assign position         = r_position;
   assign done             = r_done;
   assign error            = r_error;
   assign cmd_ready        = r_ready;
   assign busy             = r_busy;

endmodule

// File: tb/tb_ritc_phase_shift_controller.sv
// Directed bench for ritc_phase_shift_controller with a PSDONE responder that
// answers 12 cycles after each PSEN pulse.
module tb_ritc_phase_shift_controller;

   localparam int unsigned TO = 255;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [15:0] cmd_steps = '0;
   logic        cmd_reset = 1'b0;
   logic        busy, done, error;
   logic [15:0] position;
   logic [7:0]  phase_control_in;
   logic [7:0]  phase_control_out;

   logic        model_en = 1'b0;
   logic        spur = 1'b0;
   logic        model_done = 1'b0;
   int          model_cnt = 0;

   int cmp_n = 0;
   int err_n = 0;

   int cyc = 0;
   int psen_cycles = 0, psen_rises = 0, psen_up = 0, psen_dn = 0;
   int rstbit_cycles = 0, done_cnt = 0, err_cnt = 0;
   int last_psen_cyc = 0, last_err_cyc = 0;
   logic prev_psen = 1'b0;

   always #5 clk = ~clk;

   assign phase_control_out = {7'b0, model_done | spur};

   ritc_phase_shift_controller #(
      .POS_MODULO(672),
      .TIMEOUT_CYCLES(TO),
      .RST_HOLD(8)
   ) dut (
      .phase_control_clk(clk),
      .rst(rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_steps(cmd_steps),
      .cmd_reset(cmd_reset),
      .busy(busy),
      .done(done),
      .error(error),
      .position(position),
      .phase_control_in(phase_control_in),
      .phase_control_out(phase_control_out)
   );

   // PSDONE responder: one-cycle pulse 12 cycles after a sampled PSEN.
   always @(posedge clk) begin
      model_done <= 1'b0;
      if (model_cnt != 0) begin
         model_cnt <= model_cnt - 1;
         if (model_cnt == 1) model_done <= 1'b1;
      end else if (model_en && phase_control_in[0]) begin
         model_cnt <= 12;
      end
   end

   always @(negedge clk) begin
      cyc <= cyc + 1;
      prev_psen <= phase_control_in[0];
      if (phase_control_in[0]) begin
         psen_cycles <= psen_cycles + 1;
         last_psen_cyc <= cyc;
         if (!prev_psen) psen_rises <= psen_rises + 1;
         if (phase_control_in[1]) psen_up <= psen_up + 1;
         else psen_dn <= psen_dn + 1;
      end
      if (phase_control_in[7]) rstbit_cycles <= rstbit_cycles + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (error) begin
         err_cnt <= err_cnt + 1;
         last_err_cyc <= cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_n++;
      assert (obs === exp) else begin
         err_n++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [15:0] steps, input logic rs);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_steps = steps;
      cmd_reset = rs;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_reset = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int maxc);
      int n;
      n = 0;
      @(negedge clk);
      while (!(done || error) && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(done || error), 32'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int s_rises, s_cyc, s_up, s_dn, s_done, s_err, s_rb, n;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_pos", 32'(position), 32'd0);
      chk("rst_pci", 32'(phase_control_in), 32'd0);
      rst = 1'b0;
      idle(2);

      // +3 from 0
      model_en = 1'b1;
      s_rises = psen_rises; s_cyc = psen_cycles; s_up = psen_up; s_done = done_cnt;
      issue(16'd3, 1'b0);
      wait_end("p3_end", 200);
      idle(3);
      chk("p3_rises", 32'(psen_rises - s_rises), 32'd3);
      chk("p3_psen_cycles", 32'(psen_cycles - s_cyc), 32'd3);
      chk("p3_incdec_up", 32'(psen_up - s_up), 32'd3);
      chk("p3_pos", 32'(position), 32'd3);
      chk("p3_done", 32'(done_cnt - s_done), 32'd1);
      chk("p3_ready", 32'(cmd_ready), 32'd1);

      issue(16'hFFFD, 1'b0);
      wait_end("m3_end", 200);
      idle(1);
      chk("m3_pos", 32'(position), 32'd0);

      // -2 from 0 wraps through 671
      s_up = psen_up; s_dn = psen_dn; s_done = done_cnt;
      issue(16'hFFFE, 1'b0);
      n = 0;
      while (position == 16'd0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("m2_first", 32'(position), 32'd671);
      wait_end("m2_end", 200);
      idle(2);
      chk("m2_pos", 32'(position), 32'd670);
      chk("m2_dn", 32'(psen_dn - s_dn), 32'd2);
      chk("m2_up", 32'(psen_up - s_up), 32'd0);
      chk("m2_done", 32'(done_cnt - s_done), 32'd1);

      // 670 + 102 wraps to 100
      issue(16'd102, 1'b0);
      wait_end("p102_end", 3000);
      idle(1);
      chk("p102_pos", 32'(position), 32'd100);

      // MMCM reset from position 100
      s_rb = rstbit_cycles; s_rises = psen_rises; s_done = done_cnt;
      issue(16'd55, 1'b1);
      wait_end("rst_cmd_end", 50);
      idle(2);
      chk("rstcmd_bit7", 32'(rstbit_cycles - s_rb), 32'd8);
      chk("rstcmd_pos", 32'(position), 32'd0);
      chk("rstcmd_done", 32'(done_cnt - s_done), 32'd1);
      chk("rstcmd_psen", 32'(psen_rises - s_rises), 32'd0);

      // zero steps: done on the very next cycle
      s_rises = psen_rises;
      issue(16'd0, 1'b0);
      @(negedge clk);
      chk("z_done", 32'(done), 32'd1);
      chk("z_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      chk("z_done_clr", 32'(done), 32'd0);
      chk("z_psen", 32'(psen_rises - s_rises), 32'd0);

      // spurious PSDONE while idle
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      idle(2);
      chk("spur_pos", 32'(position), 32'd0);

      // timeout with responder disabled
      model_en = 1'b0;
      s_rises = psen_rises; s_done = done_cnt; s_err = err_cnt;
      issue(16'd5, 1'b0);
      wait_end("to_end", 400);
      idle(3);
      chk("to_psen", 32'(psen_rises - s_rises), 32'd1);
      chk("to_error", 32'(err_cnt - s_err), 32'd1);
      chk("to_done", 32'(done_cnt - s_done), 32'd0);
      chk("to_latency", 32'(last_err_cyc - last_psen_cyc), 32'(TO + 1));
      chk("to_pos", 32'(position), 32'd0);
      chk("to_ready", 32'(cmd_ready), 32'd1);

      // rst in WAIT during +10
      model_en = 1'b1;
      issue(16'd10, 1'b0);
      idle(5);
      s_done = done_cnt; s_err = err_cnt;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_pci", 32'(phase_control_in), 32'd0);
      chk("mid_pos", 32'(position), 32'd0);
      chk("mid_ready", 32'(cmd_ready), 32'd1);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_done", 32'(done), 32'd0);
      chk("mid_error", 32'(error), 32'd0);
      idle(20);
      chk("mid_done_cnt", 32'(done_cnt - s_done), 32'd0);
      chk("mid_err_cnt", 32'(err_cnt - s_err), 32'd0);

      s_done = done_cnt;
      issue(16'd1, 1'b0);
      wait_end("post_end", 100);
      idle(1);
      chk("post_pos", 32'(position), 32'd1);
      chk("post_done", 32'(done_cnt - s_done), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule
